// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, flag bit positions,
// compare codes and FSM state encoding.
package alu_pkg;

    // Operation codes
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_MOD  = 4'h4;
    localparam logic [3:0] OP_CMP  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_NOTA = 4'h8;
    localparam logic [3:0] OP_NOTB = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NAND = 4'hB;
    localparam logic [3:0] OP_NOR  = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_ADC  = 4'hE;
    localparam logic [3:0] OP_ILL  = 4'hF;

    // Flag word layout (7 bits)
    localparam int FLAGS_W  = 7;
    localparam int FLG_SIGN = 6;
    localparam int FLG_CARRY = 5;
    localparam int FLG_ZERO = 4;
    localparam int FLG_PAR  = 3;
    localparam int FLG_OVF  = 2;
    localparam int FLG_ERR  = 1;
    localparam int FLG_DIR  = 0;

    // Fixed flag words for the exceptional outcomes
    localparam logic [FLAGS_W-1:0] FLAGS_DIV0 = 7'h7F;
    localparam logic [FLAGS_W-1:0] FLAGS_ILL  = 7'b0000010;

    // Unsigned compare codes
    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_GT = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_multiciclo_if.sv
// Start/done bus between the control unit (master) and the ALU (slave).
interface alu_multiciclo_if #(parameter int WIDTH = 8);
    logic             start;
    logic             ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic [6:0]       flags;
    logic [1:0]       cmp;
    logic             done;

    modport master (
        output start, op, a, b, cin,
        input  ready, result, result_hi, flags, cmp, done
    );

    modport slave (
        input  start, op, a, b, cin,
        output ready, result, result_hi, flags, cmp, done
    );
endinterface

// File: rtl/alu_mul_div_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one
// 2*WIDTH accumulator. One iteration per step; WIDTH steps give the answer.
// Multiply: acc = {partial_hi, multiplier}, m = multiplicand.
// Divide:   acc = {remainder, quotient},   m = divisor.
// Outputs show the value the accumulator takes at this edge when step=1, so
// the caller can register the final answer on the same edge as the last step.
module alu_mul_div_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    logic [2*WIDTH-1:0] acc, acc_nxt, acc_view;
    logic [WIDTH-1:0]   m;
    logic [WIDTH:0]     trial, diff, psum;

    // One iteration of the selected algorithm
    always_comb begin
        trial   = acc[2*WIDTH-1:WIDTH-1];
        diff    = trial - {1'b0, m};
        psum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
        acc_nxt = acc;
        if (is_div) begin
            // Shift in the next dividend bit; keep the subtraction if it did not borrow
            if (!diff[WIDTH])
                acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            // Add multiplicand if the multiplier LSB is set, then shift right with carry
            acc_nxt = {psum, acc[WIDTH-1:1]};
        end
        acc_view = step ? acc_nxt : acc;
    end

    // Accumulator and operand register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            m   <= '0;
        end else if (load) begin
            acc <= {{WIDTH{1'b0}}, (is_div ? a : b)};
            m   <= is_div ? b : a;
        end else if (step) begin
            acc <= acc_nxt;
        end
    end

    assign hi        = acc_view[2*WIDTH-1:WIDTH];
    assign lo        = acc_view[WIDTH-1:0];
    assign remainder = acc_view[2*WIDTH-1:WIDTH];
    assign quotient  = acc_view[WIDTH-1:0];
endmodule

// File: rtl/alu_multiciclo.sv
// Registered multi-cycle ALU. Single-cycle ops complete on the accept edge;
// MUL/DIV/MOD run WIDTH iterations in the shared iterative unit.
// Owns the FSM, iteration counter, single-cycle datapath and flag generation.
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_multiciclo_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [3:0]           op_q;

    logic                 accept, is_iter, b_zero, iter_load, iter_step, last_step, upd;
    logic                 iter_is_div;
    logic [WIDTH-1:0]     it_hi, it_lo, it_quo, it_rem;

    logic [WIDTH-1:0]     b_eff;
    logic                 c_eff;
    logic [WIDTH:0]       sum;

    logic [WIDTH-1:0]     fin_res, fin_hi;
    logic [FLAGS_W-1:0]   fin_flags;
    logic [1:0]           fin_cmp;
    logic                 fin_carry, fin_ovf, fin_common;

    logic [WIDTH-1:0]     result_q, result_hi_q;
    logic [FLAGS_W-1:0]   flags_q;
    logic [1:0]           cmp_q;

    assign accept    = (state == ST_IDLE) && bus.start;
    assign is_iter   = (bus.op == OP_MUL) || (bus.op == OP_DIV) || (bus.op == OP_MOD);
    assign b_zero    = (bus.b == '0);
    // A zero divisor is resolved in IDLE; a zero multiplier trivially gives 0 in one cycle
    assign iter_load = accept && is_iter && !b_zero;
    assign iter_step = (state == ST_EXEC);
    assign last_step = iter_step && (cnt == CNT_W'(WIDTH - 1));
    assign upd       = (accept && !iter_load) || last_step;
    assign iter_is_div = (state == ST_IDLE) ? (bus.op != OP_MUL) : (op_q != OP_MUL);

    alu_mul_div_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .rst       (rst),
        .load      (iter_load),
        .step      (iter_step),
        .is_div    (iter_is_div),
        .a         (bus.a),
        .b         (bus.b),
        .hi        (it_hi),
        .lo        (it_lo),
        .quotient  (it_quo),
        .remainder (it_rem)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        bus.ready = 1'b0;
        bus.done  = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) state_nxt = iter_load ? ST_EXEC : ST_DONE;
            end
            ST_EXEC: if (last_step) state_nxt = ST_DONE;
            ST_DONE: begin
                bus.done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Iteration counter and latched op code
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            op_q <= OP_ADD;
        end else begin
            if (accept)         op_q <= bus.op;
            if (iter_load)      cnt  <= '0;
            else if (iter_step) cnt  <= cnt + 1'b1;
        end
    end

    // Adder shared by ADD / SUB / ADC
    always_comb begin
        b_eff = bus.b;
        c_eff = 1'b0;
        if (bus.op == OP_SUB) begin
            b_eff = ~bus.b;
            c_eff = 1'b1;
        end else if (bus.op == OP_ADC) begin
            c_eff = bus.cin;
        end
        sum = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};
    end

    // Result selection and flag generation for the registering edge
    always_comb begin
        fin_res    = '0;
        fin_hi     = '0;
        fin_cmp    = CMP_EQ;
        fin_carry  = 1'b0;
        fin_ovf    = 1'b0;
        fin_common = 1'b1;
        fin_flags  = '0;
        if (state == ST_EXEC) begin
            case (op_q)
                OP_MUL: begin
                    fin_res   = it_lo;
                    fin_hi    = it_hi;
                    fin_carry = |it_hi;
                    fin_ovf   = |it_hi;
                end
                OP_DIV:  fin_res = it_quo;
                default: fin_res = it_rem;
            endcase
        end else begin
            case (bus.op)
                OP_ADD, OP_ADC: begin
                    fin_res   = sum[WIDTH-1:0];
                    fin_carry = sum[WIDTH];
                    fin_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
                end
                OP_SUB: begin
                    fin_res   = sum[WIDTH-1:0];
                    fin_carry = sum[WIDTH];
                    fin_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
                end
                OP_MUL:  fin_res = '0;   // only reached with b==0
                OP_DIV, OP_MOD: begin    // only reached with b==0
                    fin_res    = '1;
                    fin_common = 1'b0;
                    fin_flags  = FLAGS_DIV0;
                end
                OP_CMP: begin
                    fin_common          = 1'b0;
                    fin_flags[FLG_ZERO] = (bus.a == bus.b);
                    if (bus.a > bus.b)      fin_cmp = CMP_GT;
                    else if (bus.a < bus.b) fin_cmp = CMP_LT;
                end
                OP_AND:  fin_res = bus.a & bus.b;
                OP_OR:   fin_res = bus.a | bus.b;
                OP_NOTA: fin_res = ~bus.a;
                OP_NOTB: fin_res = ~bus.b;
                OP_XOR:  fin_res = bus.a ^ bus.b;
                OP_NAND: fin_res = ~(bus.a & bus.b);
                OP_NOR:  fin_res = ~(bus.a | bus.b);
                OP_XNOR: fin_res = ~(bus.a ^ bus.b);
                default: begin
                    fin_common = 1'b0;
                    fin_flags  = FLAGS_ILL;
                end
            endcase
        end
        if (fin_common) begin
            fin_flags[FLG_SIGN]  = fin_res[WIDTH-1];
            fin_flags[FLG_CARRY] = fin_carry;
            fin_flags[FLG_ZERO]  = (fin_res == '0);
            fin_flags[FLG_PAR]   = ^fin_res;
            fin_flags[FLG_OVF]   = fin_ovf;
            fin_flags[FLG_ERR]   = 1'b0;
            fin_flags[FLG_DIR]   = 1'b0;
        end
    end

    // Output registers: change only on the completing edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
            cmp_q       <= CMP_EQ;
        end else if (upd) begin
            result_q    <= fin_res;
            result_hi_q <= fin_hi;
            flags_q     <= fin_flags;
            cmp_q       <= fin_cmp;
        end
    end

    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.flags     = flags_q;
    assign bus.cmp       = cmp_q;
endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed + randomized bench for alu_multiciclo (WIDTH=8) against an
// arithmetic reference model.
module tb_alu_multiciclo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    alu_multiciclo_if #(.WIDTH(8)) bus ();
    alu_multiciclo #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model straight from the op definitions
    function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic ci, output logic [7:0] r, output logic [7:0] hi,
                                  output logic [6:0] f, output logic [1:0] c, output int lat);
        int s, ss, p;
        logic carry, ovf, common;
        r = 0; hi = 0; c = 0; lat = 1; carry = 0; ovf = 0; common = 1; f = 0;
        case (op)
            4'h0, 4'hE: begin
                s  = int'(a) + int'(b) + ((op == 4'hE) ? int'(ci) : 0);
                ss = int'($signed(a)) + int'($signed(b)) + ((op == 4'hE) ? int'(ci) : 0);
                r = 8'(s); carry = (s > 255); ovf = (ss > 127) || (ss < -128);
            end
            4'h1: begin
                ss = int'($signed(a)) - int'($signed(b));
                r = a - b; carry = (a >= b); ovf = (ss > 127) || (ss < -128);
            end
            4'h2: begin
                p = int'(a) * int'(b);
                r = 8'(p); hi = 8'(p >> 8); carry = (hi != 0); ovf = carry;
                lat = (b == 0) ? 1 : 9;
            end
            4'h3, 4'h4: begin
                if (b == 0) begin r = 8'hFF; f = 7'h7F; common = 0; end
                else begin r = (op == 4'h3) ? a / b : a % b; lat = 9; end
            end
            4'h5: begin
                common = 0; f = (a == b) ? 7'h10 : 7'h00;
                c = (a == b) ? 2'b00 : ((a > b) ? 2'b01 : 2'b10);
            end
            4'h6: r = a & b;
            4'h7: r = a | b;
            4'h8: r = ~a;
            4'h9: r = ~b;
            4'hA: r = a ^ b;
            4'hB: r = ~(a & b);
            4'hC: r = ~(a | b);
            4'hD: r = ~(a ^ b);
            default: begin common = 0; f = 7'b0000010; end
        endcase
        if (common) f = {r[7], carry, (r == 0), 1'($countones(r) % 2), ovf, 2'b00};
    endfunction

    // Issue one op from a negedge, wait for done, check everything, check hold.
    // pulse_at>0 pulses a stray start (ADD) at that cycle of the wait.
    task automatic run_op(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input int pulse_at, input string tag);
        logic [7:0] er, eh;
        logic [6:0] ef;
        logic [1:0] ec;
        int el, lat;
        logic ready_low;
        model(o, av, bv, ci, er, eh, ef, ec, el);
        bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv; bus.cin = ci;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        bus.a = 8'($urandom); bus.b = 8'($urandom); bus.cin = 1'($urandom);
        lat = 1; ready_low = 1'b1;
        while (!bus.done && lat < 40) begin
            if (bus.ready) ready_low = 1'b0;
            if (lat == pulse_at) begin bus.start = 1'b1; bus.op = 4'h0; end
            else bus.start = 1'b0;
            @(posedge clk); @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check({tag, " done_seen"}, bus.done, 1'b1);
        check({tag, " latency"}, lat, el);
        check({tag, " result"}, bus.result, er);
        check({tag, " result_hi"}, bus.result_hi, eh);
        check({tag, " flags"}, bus.flags, ef);
        check({tag, " cmp"}, bus.cmp, ec);
        if (el > 1) check({tag, " ready_low_busy"}, ready_low, 1'b1);
        @(posedge clk); @(negedge clk);
        check({tag, " done_pulse_end"}, {bus.done, bus.ready}, 2'b01);
        check({tag, " result_hold"}, bus.result, er);
    endtask

    initial begin
        int ndone;
        logic [3:0] rop;
        logic [7:0] ra, rb;
        bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.cin = 0;

        // Reset state
        #2 rst = 1'b1;
        #1;
        check("reset_result", bus.result, 8'h00);
        check("reset_flags", bus.flags, 7'h00);
        check("reset_ready_done", {bus.ready, bus.done}, 2'b10);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // Directed plan
        run_op(4'h0, 8'h7F, 8'h01, 1'b0, 0, "add_7f_01");
        check("add_plan_flags", bus.flags, 7'h4C);
        run_op(4'h1, 8'h05, 8'h05, 1'b0, 0, "sub_eq");
        run_op(4'h5, 8'h03, 8'h09, 1'b0, 0, "cmp_lt");
        check("cmp_plan_code", bus.cmp, 2'b10);
        run_op(4'h2, 8'hFF, 8'hFF, 1'b0, 4, "mul_ff_ff");
        check("mul_plan_product", {bus.result_hi, bus.result}, 16'hFE01);
        check("mul_plan_flags", bus.flags, 7'h2C);
        run_op(4'h3, 8'd200, 8'd7, 1'b0, 0, "div_200_7");
        run_op(4'h4, 8'd200, 8'd7, 1'b0, 0, "mod_200_7");
        run_op(4'h3, 8'd10, 8'd0, 1'b0, 0, "div_by_zero");

        // Reset in the middle of a MUL
        bus.start = 1'b1; bus.op = 4'h2; bus.a = 8'h12; bus.b = 8'h34;
        @(posedge clk); @(negedge clk); bus.start = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        #1 rst = 1'b1;
        #1;
        check("rst_mid_result", {bus.result, bus.result_hi}, 16'h0000);
        check("rst_mid_flags_cmp", {bus.flags, bus.cmp}, 9'h000);
        check("rst_mid_ready_done", {bus.ready, bus.done}, 2'b10);
        @(negedge clk); rst = 1'b0;
        ndone = 0;
        repeat (12) begin @(posedge clk); @(negedge clk); ndone += int'(bus.done); end
        check("rst_mid_no_done", ndone, 0);
        run_op(4'hE, 8'hFF, 8'h00, 1'b1, 0, "adc_ff_0_1");
        run_op(4'hF, 8'h5A, 8'hA5, 1'b0, 0, "illegal");

        // Back-to-back starts held high: one accept every 2 cycles
        bus.start = 1'b1; bus.op = 4'h0; bus.a = 8'd1; bus.b = 8'd2;
        ndone = 0;
        repeat (8) begin @(posedge clk); @(negedge clk); ndone += int'(bus.done); end
        bus.start = 1'b0;
        check("b2b_done_count", ndone, 4);
        check("b2b_result", bus.result, 8'd3);
        @(posedge clk); @(negedge clk);

        // Random ops against the model
        for (int i = 0; i < 80; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            run_op(rop, ra, rb, 1'($urandom), 0, $sformatf("rand%0d_op%0h", i, rop));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
